// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/opcode request channel and result/flag response channel
// for alu_seq. The master modport is the source/consumer side; the slave
// modport is the ALU.
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid && ready are both 1. A source raising valid keeps its
// payload stable until that transfer. ready may be asserted independently of
// valid. Neither ready depends combinationally on the valid it pairs with.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             negative;
    logic             err;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, res, carry, overflow, zero, negative, err
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, res, carry, overflow, zero, negative, err
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with valid/ready on request and result.
// Single-cycle ops are evaluated from the live bus at acceptance and the
// registered result appears one cycle later. With ALU_SEQ_MUL_EN defined,
// opcode 12 runs a WIDTH-iteration shift-add multiplier in the EXEC state;
// without it, opcode 12 is treated as an illegal opcode.
// state_dbg exposes the FSM state: 0 = IDLE, 1 = DONE, 2 = EXEC.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   bus,
    output logic [1:0] state_dbg
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DONE = 2'd1,
        EXEC = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] res_q;
    logic             carry_q, overflow_q, zero_q, negative_q, err_q;

    // Combinational evaluation of the single-cycle ops on the live request.
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry, alu_overflow, alu_err, is_mul;
    logic [WIDTH:0]   sum_add, sum_sub;
    logic [SHW-1:0]   shamt;

`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod, prod_nxt;
    logic [SHW-1:0]     cnt;
    logic [WIDTH:0]     upper_sum;
    logic               last_iter;
`endif

    assign shamt = bus.b[SHW-1:0];

    // Opcode decode and single-cycle result/flag evaluation.
    always_comb begin
        alu_res      = '0;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        alu_err      = 1'b0;
        is_mul       = 1'b0;
        sum_add      = {1'b0, bus.a} + {1'b0, bus.b};
        sum_sub      = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(1);
        case (bus.op)
            4'd0: begin
                alu_res      = sum_add[WIDTH-1:0];
                alu_carry    = sum_add[WIDTH];
                alu_overflow = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                               (sum_add[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'd1: begin
                alu_res      = sum_sub[WIDTH-1:0];
                alu_carry    = sum_sub[WIDTH];
                alu_overflow = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                               (sum_sub[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'd2:  alu_res = ~bus.a;
            4'd3:  alu_res = bus.a & bus.b;
            4'd4:  alu_res = bus.a | bus.b;
            4'd5:  alu_res = bus.a ^ bus.b;
            4'd6:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            4'd7:  alu_res = {{(WIDTH-1){1'b0}}, (bus.a == bus.b)};
            4'd8:  alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            4'd9:  alu_res = bus.a << shamt;
            4'd10: alu_res = bus.a >> shamt;
            4'd11: alu_res = $signed(bus.a) >>> shamt;
`ifdef ALU_SEQ_MUL_EN
            4'd12: is_mul = 1'b1;
`endif
            default: alu_err = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    // One shift-add step: conditionally add the multiplicand into the upper
    // half, then shift the whole product right by one.
    always_comb begin
        upper_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} +
                    (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        prod_nxt  = {upper_sum, prod[WIDTH-1:1]};
        last_iter = (cnt == SHW'(WIDTH-1));
    end
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = rst_n;
                if (bus.in_valid) state_nxt = is_mul ? EXEC : DONE;
            end
`ifdef ALU_SEQ_MUL_EN
            EXEC: begin
                if (last_iter) state_nxt = DONE;
            end
`endif
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Result/flag registers and multiplier datapath; held while in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q      <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
            err_q      <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            mcand      <= '0;
            prod       <= '0;
            cnt        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
`ifdef ALU_SEQ_MUL_EN
                        if (is_mul) begin
                            mcand <= bus.a;
                            prod  <= {{WIDTH{1'b0}}, bus.b};
                            cnt   <= '0;
                        end else begin
`else
                        begin
`endif
                            res_q      <= alu_res;
                            carry_q    <= alu_carry;
                            overflow_q <= alu_overflow;
                            zero_q     <= (alu_res == '0);
                            negative_q <= alu_res[WIDTH-1];
                            err_q      <= alu_err;
                        end
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                EXEC: begin
                    prod <= prod_nxt;
                    cnt  <= cnt + SHW'(1);
                    if (last_iter) begin
                        res_q      <= prod_nxt[WIDTH-1:0];
                        carry_q    <= |prod_nxt[2*WIDTH-1:WIDTH];
                        overflow_q <= 1'b0;
                        zero_q     <= (prod_nxt[WIDTH-1:0] == '0);
                        negative_q <= prod_nxt[WIDTH-1];
                        err_q      <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.res      = res_q;
    assign bus.carry    = carry_q;
    assign bus.overflow = overflow_q;
    assign bus.zero     = zero_q;
    assign bus.negative = negative_q;
    assign bus.err      = err_q;
    assign state_dbg    = state;
endmodule
